// File: rtl/axis_frame_sink_if.sv
// AXI4-Stream beat bundle shared by the frame sink and its upstream source.
// The master drives the beat; the slave returns tready.
interface axis_frame_sink_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_sink.sv
// AXI4-Stream receive endpoint: stores one frame, publishes a descriptor and
// holds the buffer until the consumer releases it; registered read port.
module axis_frame_sink #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rstn_local,
    axis_frame_sink_if.slave      s_axis,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [ADDR_WIDTH:0]   frame_len,
    output logic [KEEP_WIDTH-1:0] frame_keep,
    output logic                  frame_err,
    output logic                  frame_ovf,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [0:0] {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH + 1)'(1);

    state_e                  state_q;
    state_e                  state_d;
    logic                    run_q;
    logic [ADDR_WIDTH:0]     wr_cnt_q;
    logic [ADDR_WIDTH:0]     wr_cnt_d;
    logic                    err_acc_q;
    logic                    err_acc_d;
    logic                    ovf_acc_q;
    logic                    ovf_acc_d;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     len_d;
    logic [KEEP_WIDTH-1:0]   keep_q;
    logic [KEEP_WIDTH-1:0]   keep_d;
    logic                    ferr_q;
    logic                    ferr_d;
    logic                    fovf_q;
    logic                    fovf_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    clr_s;
    logic                    tready_s;
    logic                    accept_s;
    logic                    room_s;
    logic                    store_s;

    // run_q keeps tready low for the cycle the clear is applied
    assign clr_s    = ~rstn | ~rstn_local;
    assign tready_s = (state_q == RECV) & run_q;
    assign accept_s = s_axis.tvalid & tready_s;
    assign room_s   = (wr_cnt_q < DEPTH_CNT);
    assign store_s  = accept_s & room_s;

    assign s_axis.tready = tready_s;
    assign frame_valid   = (state_q == HOLD);
    assign frame_len     = len_q;
    assign frame_keep    = keep_q;
    assign frame_err     = ferr_q;
    assign frame_ovf     = fovf_q;
    assign rd_data       = rd_data_q;

    // Next-state, accumulator and descriptor-latch logic
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        err_acc_d = err_acc_q;
        ovf_acc_d = ovf_acc_q;
        len_d     = len_q;
        keep_d    = keep_q;
        ferr_d    = ferr_q;
        fovf_d    = fovf_q;
        case (state_q)
            RECV: begin
                if (accept_s) begin
                    if (room_s) begin
                        wr_cnt_d = wr_cnt_q + ONE_CNT;
                    end else begin
                        ovf_acc_d = 1'b1;
                    end
                    err_acc_d = err_acc_q | s_axis.tuser[0];
                    if (s_axis.tlast) begin
                        len_d   = wr_cnt_d;
                        keep_d  = s_axis.tkeep;
                        ferr_d  = err_acc_d;
                        fovf_d  = ovf_acc_d;
                        state_d = HOLD;
                    end else begin
                        state_d = RECV;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    state_d   = RECV;
                    wr_cnt_d  = '0;
                    err_acc_d = 1'b0;
                    ovf_acc_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = RECV;
            end
        endcase
    end

    // Control and descriptor registers; either reset clears them
    always_ff @(posedge clk) begin
        if (clr_s) begin
            state_q   <= RECV;
            run_q     <= 1'b0;
            wr_cnt_q  <= '0;
            err_acc_q <= 1'b0;
            ovf_acc_q <= 1'b0;
            len_q     <= '0;
            keep_q    <= '0;
            ferr_q    <= 1'b0;
            fovf_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            wr_cnt_q  <= wr_cnt_d;
            err_acc_q <= err_acc_d;
            ovf_acc_q <= ovf_acc_d;
            len_q     <= len_d;
            keep_q    <= keep_d;
            ferr_q    <= ferr_d;
            fovf_q    <= fovf_d;
        end
    end

    // Frame buffer write; beats beyond DEPTH are dropped
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem[wr_cnt_q[ADDR_WIDTH-1:0]] <= s_axis.tdata;
        end
    end

    // Registered read port, cleared only by the global reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_axis_frame_sink.sv
// Randomised self-checking bench for axis_frame_sink (DEPTH=8, 16-bit beats)
// against a frame-level reference model.
module tb_axis_frame_sink;
    localparam int DW    = 16;
    localparam int KW    = 2;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rstn_local;
    logic          frame_valid;
    logic          frame_ready;
    logic [AW:0]   frame_len;
    logic [KW-1:0] frame_keep;
    logic          frame_err;
    logic          frame_ovf;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] frm_data [0:15];
    logic          frm_user [0:15];
    logic [KW-1:0] frm_keep;

    bit            mon_en = 1'b0;
    int            mon_low = 0;
    logic [DW-1:0] acc_q [$];

    always #5 clk = ~clk;

    axis_frame_sink_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1)) s_axis ();

    axis_frame_sink #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(1), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rstn(rstn), .rstn_local(rstn_local), .s_axis(s_axis),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_len(frame_len),
        .frame_keep(frame_keep), .frame_err(frame_err), .frame_ovf(frame_ovf),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Bus monitor: tready-low cycles and every accepted beat
    always @(posedge clk) begin
        if (mon_en) begin
            if (!s_axis.tready) mon_low <= mon_low + 1;
            if (s_axis.tvalid && s_axis.tready) acc_q.push_back(s_axis.tdata);
        end
    end

    function automatic int exp_len(input int n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    function automatic bit exp_err(input int n);
        bit e = 1'b0;
        for (int i = 0; i < n; i++) e = e | frm_user[i];
        return e;
    endfunction

    task automatic gen_frame(input int n, input int err_pct);
        for (int i = 0; i < n; i++) begin
            frm_data[i] = DW'($urandom);
            frm_user[i] = ($urandom_range(0, 99) < err_pct);
        end
        frm_keep = KW'($urandom_range(1, 3));
    endtask

    task automatic drive_frame(input int n, input int gap_pct, input bit with_last);
        int wait_cnt;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                s_axis.tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = frm_data[i];
            s_axis.tuser  = frm_user[i];
            s_axis.tlast  = with_last && (i == n - 1);
            s_axis.tkeep  = s_axis.tlast ? frm_keep : KW'($urandom);
            wait_cnt = 0;
            while (!s_axis.tready && wait_cnt < 100) begin
                @(posedge clk); #1;
                wait_cnt++;
            end
            if (!s_axis.tready) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_timeout: tready=0 after %0d cycles, want 1", wait_cnt);
            end
            @(posedge clk); #1;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic release_frame();
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; rstn_local = 1'b1; frame_ready = 1'b0; rd_addr = '0;
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = '0;
        s_axis.tkeep = '0; s_axis.tuser = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({s_axis.tready, frame_valid, frame_len, frame_keep, frame_err, frame_ovf, rd_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b fv=%b len=%0d keep=%h err=%b ovf=%b rd=%h, want all 0",
                     s_axis.tready, frame_valid, frame_len, frame_keep, frame_err, frame_ovf, rd_data);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_axis.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got tready=%b, want 1", s_axis.tready);
        end
    endtask

    task automatic test_basic();
        frm_data[0] = 16'h0011; frm_data[1] = 16'h0022;
        frm_data[2] = 16'h0033; frm_data[3] = 16'h0044;
        for (int i = 0; i < 4; i++) frm_user[i] = 1'b0;
        frm_keep = 2'h1;
        drive_frame(4, 0, 1'b1);
        n_checks++;
        if ({frame_valid, s_axis.tready, frame_len, frame_keep, frame_err, frame_ovf} !== {1'b1, 1'b0, 4'd4, 2'h1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_desc: got fv=%b rdy=%b len=%0d keep=%h err=%b ovf=%b, want 1 0 4 1 0 0",
                     frame_valid, s_axis.tready, frame_len, frame_keep, frame_err, frame_ovf);
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== frm_data[a]) begin
                n_fail++;
                $display("FAIL basic_read[%0d]: got %h, want %h", a, rd_data, frm_data[a]);
            end
        end
        release_frame();
        n_checks++;
        if ({frame_valid, s_axis.tready} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_release: got fv=%b rdy=%b, want 0 1", frame_valid, s_axis.tready);
        end
    endtask

    task automatic test_gaps_hold();
        drive_frame(4, 40, 1'b1);
        n_checks++;
        if ({frame_valid, frame_len, frame_keep, frame_err, frame_ovf} !== {1'b1, 4'd4, 2'h1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL gaps_desc: got fv=%b len=%0d keep=%h err=%b ovf=%b, want 1 4 1 0 0",
                     frame_valid, frame_len, frame_keep, frame_err, frame_ovf);
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({s_axis.tready, frame_valid} !== 2'b01) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: got rdy=%b fv=%b, want 0 1", c, s_axis.tready, frame_valid);
            end
            @(posedge clk); #1;
        end
        release_frame();
        n_checks++;
        if (s_axis.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got tready=%b, want 1", s_axis.tready);
        end
    endtask

    task automatic test_overflow();
        gen_frame(11, 0);
        drive_frame(11, 20, 1'b1);
        n_checks++;
        if ({frame_valid, frame_len, frame_keep, frame_err, frame_ovf} !== {1'b1, 4'd8, frm_keep, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_desc: got fv=%b len=%0d keep=%h err=%b ovf=%b, want 1 8 %h 0 1",
                     frame_valid, frame_len, frame_keep, frame_err, frame_ovf, frm_keep);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== frm_data[a]) begin
                n_fail++;
                $display("FAIL ovf_read[%0d]: got %h, want %h", a, rd_data, frm_data[a]);
            end
        end
        release_frame();
    endtask

    task automatic test_error();
        gen_frame(3, 0);
        frm_user[1] = 1'b1;
        drive_frame(3, 0, 1'b1);
        n_checks++;
        if ({frame_len, frame_err, frame_ovf} !== {4'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL err_desc: got len=%0d err=%b ovf=%b, want 3 1 0", frame_len, frame_err, frame_ovf);
        end
        release_frame();
        gen_frame(3, 0);
        drive_frame(3, 0, 1'b1);
        n_checks++;
        if ({frame_len, frame_err} !== {4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL err_clean: got len=%0d err=%b, want 3 0", frame_len, frame_err);
        end
        release_frame();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q [$];
        int lens [0:5];
        int bad = 0;
        acc_q.delete();
        mon_low = 0;
        frame_ready = 1'b1;
        mon_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            lens[f] = $urandom_range(1, 6);
            gen_frame(lens[f], 15);
            for (int i = 0; i < lens[f]; i++) exp_q.push_back(frm_data[i]);
            drive_frame(lens[f], 0, 1'b1);
            n_checks++;
            if ({frame_valid, frame_len, frame_keep, frame_err, frame_ovf} !==
                {1'b1, 4'(lens[f]), frm_keep, exp_err(lens[f]), 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_desc[%0d]: got fv=%b len=%0d keep=%h err=%b ovf=%b, want 1 %0d %h %b 0",
                         f, frame_valid, frame_len, frame_keep, frame_err, frame_ovf,
                         lens[f], frm_keep, exp_err(lens[f]));
            end
        end
        @(posedge clk); #1;
        mon_en = 1'b0;
        frame_ready = 1'b0;
        n_checks++;
        if (mon_low != 6) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d tready-low cycles, want 6", mon_low);
        end
        n_checks++;
        if (acc_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats accepted, want %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) if (acc_q[i] !== exp_q[i]) bad++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL b2b_data: got %0d mismatching beats, want 0", bad);
            end
        end
    endtask

    task automatic test_local_reset();
        gen_frame(4, 0);
        drive_frame(2, 0, 1'b0);
        rstn_local = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({s_axis.tready, frame_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL lrst_during: got rdy=%b fv=%b, want 0 0", s_axis.tready, frame_valid);
        end
        rstn_local = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({s_axis.tready, frame_valid, frame_len} !== {1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL lrst_after: got rdy=%b fv=%b len=%0d, want 1 0 0", s_axis.tready, frame_valid, frame_len);
        end
        gen_frame(2, 0);
        drive_frame(2, 0, 1'b1);
        n_checks++;
        if ({frame_valid, frame_len, frame_ovf} !== {1'b1, 4'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL lrst_new: got fv=%b len=%0d ovf=%b, want 1 2 0", frame_valid, frame_len, frame_ovf);
        end
        for (int a = 0; a < 2; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== frm_data[a]) begin
                n_fail++;
                $display("FAIL lrst_read[%0d]: got %h, want %h", a, rd_data, frm_data[a]);
            end
        end
        release_frame();
    endtask

    task automatic test_random();
        int n;
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(1, 12);
            gen_frame(n, 20);
            drive_frame(n, 30, 1'b1);
            n_checks++;
            if ({frame_valid, frame_len, frame_keep, frame_err, frame_ovf} !==
                {1'b1, 4'(exp_len(n)), frm_keep, exp_err(n), (n > DEPTH)}) begin
                n_fail++;
                $display("FAIL rand_desc[%0d] n=%0d: got fv=%b len=%0d keep=%h err=%b ovf=%b, want 1 %0d %h %b %b",
                         f, n, frame_valid, frame_len, frame_keep, frame_err, frame_ovf,
                         exp_len(n), frm_keep, exp_err(n), (n > DEPTH));
            end
            for (int a = 0; a < exp_len(n); a++) begin
                rd_addr = AW'(a);
                @(posedge clk); #1;
                n_checks++;
                if (rd_data !== frm_data[a]) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d][%0d]: got %h, want %h", f, a, rd_data, frm_data[a]);
                end
            end
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            release_frame();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps_hold();
        test_overflow();
        test_error();
        test_back_to_back();
        test_local_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_frame_sink.md
# axis_frame_sink

AXI4-Stream receive endpoint that terminates a stream (typically fed by the design's skid-buffer register stage). It accepts beats into a local single-frame buffer and reports each completed frame as a descriptor (length, last-beat keep, error, overflow). The buffer is held until the consumer releases it, and a registered random-access read port exposes the stored frame to downstream logic.

## Interface
- DATA_WIDTH, 8, beat width in bits
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 1, tuser width; bit 0 is the error flag
- DEPTH, 256, buffer depth in beats; power of 2, ≥2
- ADDR_WIDTH, $clog2(DEPTH), buffer address width

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- rstn_local  in  1  synchronous local clear, active-low, same effect as rstn on control state
- s_axis_tdata  in  DATA_WIDTH  stream data
- s_axis_tkeep  in  KEEP_WIDTH  byte qualifiers
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- s_axis_tlast  in  1  last beat of frame
- s_axis_tuser  in  USER_WIDTH  sideband; bit 0 = beat error
- frame_valid  out  1  completed frame held in buffer
- frame_ready  in  1  consumer releases buffer
- frame_len  out  ADDR_WIDTH+1  stored beats, 1..DEPTH
- frame_keep  out  KEEP_WIDTH  tkeep of the tlast beat
- frame_err  out  1  OR of tuser[0] over all beats of the frame
- frame_ovf  out  1  frame exceeded DEPTH beats; excess beats discarded
- rd_addr  in  ADDR_WIDTH  buffer read address
- rd_data  out  DATA_WIDTH  mem[rd_addr], registered

## Operation
- Two states:
  - RECV: s_axis_tready=1.
  - HOLD: s_axis_tready=0, frame_valid=1.
- Both outputs are decoded directly from the state register.
- Beat accepted = s_axis_tvalid & s_axis_tready.
- RECV, beat accepted, wr_cnt < DEPTH:
  - mem[wr_cnt[ADDR_WIDTH-1:0]] <= tdata; wr_cnt++.
  - err_acc |= tuser[0].
- RECV, beat accepted, wr_cnt == DEPTH:
  - Data discarded; ovf_acc <= 1; wr_cnt saturates.
  - err_acc still accumulates tuser[0].
- RECV, beat accepted with tlast:
  - Latch frame_len = final wr_cnt (including this beat if stored), frame_keep = tkeep.
  - Latch frame_err = err_acc | tuser[0] and frame_ovf = ovf_acc | (beat discarded).
  - Go to HOLD.
- HOLD, frame_ready=1:
  - Go to RECV; wr_cnt, err_acc, ovf_acc <= 0.
  - Descriptor outputs keep their last values until the next latch.
- frame_ready while frame_valid=0: ignored.
- Zero-length frames are impossible; a tlast beat always counts.
- Read port:
  - rd_data <= mem[rd_addr] every cycle, regardless of state.
  - Contents are defined only for addresses < frame_len while in HOLD.
  - Same-cycle write/read of one address returns old data.
- Memory is not reset.

## Timing
- Reset (rstn=0 or rstn_local=0 at a clock edge) drives:
  - state=RECV, s_axis_tready=0 during reset, frame_valid=0.
  - frame_len=0, frame_keep=0, frame_err=0, frame_ovf=0, rd_data=0 (rstn only for rd_data), all counters 0.
- s_axis_tready=1 from the first edge after reset deasserts.
- Reset mid-frame or in HOLD discards the partial or held frame, with no descriptor.
- tlast beat accepted at edge N: frame_valid=1 and s_axis_tready=0 from N+1.
- Descriptor fields are valid in the same cycle frame_valid rises.
- frame_valid&frame_ready at edge M: frame_valid=0 and s_axis_tready=1 from M+1.
- Minimum frame-to-frame gap is therefore 1 HOLD cycle plus the consumer's response time.
- Throughput in RECV is 1 beat/cycle; no bubbles.
- rd_data latency is 1 cycle from rd_addr.
- AXIS rules:
  - tready does not depend combinationally on tvalid.
  - The sender may hold tvalid across tready=0; that beat is accepted only after the return to RECV.

## Test plan
- Continuous 4-beat frame (tdata 0x11,0x22,0x33,0x44; tkeep on last = 0x1; tuser=0) -> frame_valid one cycle after the tlast beat; frame_len=4, frame_keep=0x1, err=0, ovf=0. Reading rd_addr 0..3 returns 0x11..0x44 one cycle later.
- Same frame with random tvalid gaps and frame_ready held low 10 cycles -> identical descriptor. s_axis_tready=0 all 10 cycles; tready=1 the cycle after frame_ready pulses.
- DEPTH=8, 11-beat frame -> frame_len=8, frame_ovf=1. mem holds beats 0..7; beats 8..10 are consumed (tready=1) but not stored.
- 3-beat frame with tuser[0]=1 on beat 1 only -> frame_err=1. The next clean frame reports frame_err=0.
- Back-to-back frames with frame_ready tied high -> every descriptor correct. Exactly one tready-low cycle between frames; no beat lost or duplicated.
- rstn_local pulsed after 2 beats of a frame, then a new 2-beat frame -> no descriptor for the partial frame. The new frame reports frame_len=2 with its own data at addresses 0..1.
